// File: rtl/cs_pkg.sv
// Shared definitions for the sliding-window average block and its result writer.
package cs_pkg;

  localparam int N  = 9;
  localparam int DW = N + 1;

  typedef enum logic [1:0] {
    WARM  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cs_state_t;

endpackage

// File: rtl/cs_sync_fifo.sv
// First-word fall-through synchronous FIFO; full/empty come from an extra pointer bit.
module cs_sync_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[PW-1:0]];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/cs_result_writer.sv
// Drops warm-up results, queues valid ones and writes COUNT of them to result memory.
module cs_result_writer
  import cs_pkg::*;
#(
  parameter int DW     = cs_pkg::DW,
  parameter int WARMUP = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 10,
  parameter int COUNT  = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_y,
  input  logic                   mem_ready,
  output logic                   mem_wen,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  output logic                   overflow,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fill_level,
  output cs_state_t              state
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int WCW = (WARMUP < 2) ? 1 : $clog2(WARMUP);
  localparam int PCW = $clog2(COUNT + 1);
  localparam cs_state_t RESET_STATE = (WARMUP == 0) ? RUN : WARM;

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [DW-1:0]  head;
  logic [WCW-1:0] warm_cnt;
  logic [PCW-1:0] push_cnt;

  // Handshake: a write completes on any cycle with mem_wen && mem_ready; until
  // then mem_wen, mem_addr and mem_wdata hold, and completion pops the head.
  assign mem_wen   = !empty && ((state == RUN) || (state == DRAIN));
  assign pop       = mem_wen && mem_ready;
  assign push      = (state == RUN) && in_valid && (!full || pop);
  assign mem_wdata = mem_wen ? head : '0;

  cs_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_y),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fill_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RESET_STATE;
      warm_cnt <= '0;
      push_cnt <= '0;
      mem_addr <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (pop) mem_addr <= mem_addr + AW'(1);
      case (state)
        WARM: begin
          if (in_valid) begin
            warm_cnt <= warm_cnt + WCW'(1);
            if (warm_cnt == WCW'(WARMUP - 1)) state <= RUN;
          end
        end
        RUN: begin
          if (in_valid && !push) overflow <= 1'b1;
          if (push) begin
            push_cnt <= push_cnt + PCW'(1);
            if (push_cnt == PCW'(COUNT - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish on the edge that retires the last queued entry.
          if (empty || ((fill_level == LW'(1)) && pop)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: doc/cs_result_writer.md
Name: cs_result_writer

Overview:
- Downstream stage of the sliding-window approximate-average block.
- Accepts the per-cycle 10-bit Y result stream and discards the warm-up results produced while the 9-sample window is still filling.
- Buffers valid results in a small FIFO and writes them sequentially into result memory over a ready/wen handshake.
- Raises done after a programmed number of results has been written; flags dropped samples via a sticky overflow bit.

Parameters:
- DW, 10, result data width (matches Y width N+1 with N=9)
- WARMUP, 8, number of leading in_valid samples discarded after reset
- DEPTH, 8, FIFO depth in entries (power of 2)
- AW, 10, memory address width
- COUNT, 1000, number of results to write before done (1..2^AW)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_y carries a result this cycle
- in_y  in  DW  result from the averaging stage
- mem_ready  in  1  memory accepts the write this cycle
- mem_wen  out  1  write request
- mem_addr  out  AW  write address
- mem_wdata  out  DW  write data (FIFO head)
- overflow  out  1  sticky: a post-warm-up sample was dropped because the FIFO was full
- done  out  1  all COUNT results written; held until reset
- fill_level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset, asynchronous, is permitted at any time including mid-write. Required post-reset values:
  - state=WARM; FIFO empty; all counters 0.
  - mem_wen=0, mem_addr=0, mem_wdata=0, overflow=0, done=0, fill_level=0.
- FSM states: WARM, RUN, DRAIN, DONE.
- WARM:
  - Each in_valid increments warm_cnt; in_y is discarded.
  - When in_valid arrives with warm_cnt==WARMUP-1, go to RUN; that sample is also discarded.
  - WARMUP=0 means reset goes straight to RUN.
- RUN:
  - in_valid pushes in_y when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped, overflow is set, and the sample does not count.
  - push_cnt increments per accepted push.
  - The push that makes push_cnt==COUNT moves the FSM to DRAIN.
- DRAIN: in_valid is ignored. When the FIFO is empty and no write is pending, go to DONE.
- DONE:
  - done=1, mem_wen=0, inputs ignored.
  - Only reset leaves this state.
- Write side:
  - mem_wen = FIFO not empty and state in {RUN, DRAIN}.
  - mem_wdata = FIFO head (first-word fall-through).
  - The write completes on a cycle with mem_wen && mem_ready. That completion pops the FIFO and increments mem_addr on the next edge.
  - mem_wen, mem_addr and mem_wdata hold stable while mem_ready=0.
- Latency: a sample pushed at edge t into an empty FIFO gives mem_wen=1 with that data during cycle t+1.
- Address:
  - Starts at 0 and increments by 1 per completed write.
  - The last write goes to COUNT-1.
  - mem_addr never wraps (COUNT ≤ 2^AW).
- FIFO:
  - Pointers wrap modulo DEPTH.
  - Full/empty are derived from an extra pointer bit.
  - Simultaneous push and pop leave fill_level unchanged.
- Overflow is sticky and cleared only by reset.

Decomposition:
- Package cs_pkg:
  - N=9 and DW=10 (result width).
  - State enumeration WARM/RUN/DRAIN/DONE, shared with the averaging block's bench.
- Sub-module cs_sync_fifo:
  - Parameters DW and DEPTH; same clk and async active-high reset.
  - Ports push, pop, din, dout (first-word fall-through), full, empty, level.
  - The writer instantiates it once.

Test Plan:
- Warm-up discard: WARMUP=8, COUNT=4, mem_ready=1, in_y=1..12 every cycle -> writes 9,10,11,12 to addr 0..3; done=1 one cycle after the final write; overflow=0.
- Backpressure: WARMUP=0, DEPTH=8, COUNT=8, mem_ready=0 while 8 samples 100..107 are pushed, then mem_ready=1 -> fill_level reaches 8; writes 100..107 to addr 0..7; no overflow.
- Overflow: DEPTH=4, mem_ready=0, 6 valid samples 1..6 after warm-up -> FIFO holds 1..4; overflow=1; 5 and 6 are never written; push_cnt=4.
- Full with simultaneous pop: FIFO full (4 entries), mem_ready=1 in the same cycle as in_valid with in_y=55 -> entry accepted; fill_level stays 4; overflow stays 0.
- Gapped input: in_valid toggling 1,0,1,0 with in_y=500,X,501,X, COUNT=2 -> writes 500@0 and 501@1; the invalid-cycle data is never written.
- Reset mid-operation: assert reset after 2 of 4 writes with 3 entries queued -> all outputs return to 0 immediately. After release, 8 new warm-up samples are discarded again and addressing restarts at 0.
